// File: rtl/quad_gate_bist_ctrl.sv
// Self-test sequencer for one quad 2-input gate package. Walks all 256
// {A,B} input patterns across the four gates in parallel, waits a settle
// interval, compares the synchronized gate outputs against the expected
// function and accumulates a per-gate fail mask plus the first bad vector.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; drive parked at 0 (or 0xFF after a run)
//   SETTLE | drive applied, counting down the settle interval
//   CHECK  | compare y_s against expected, advance or finish
//   DONE   | one-cycle completion, pass latched on exit
module quad_gate_bist_ctrl #(
    parameter int FUNC          = 0,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic       abort_i,
    output logic [3:0] drive_a_o,
    output logic [3:0] drive_b_o,
    input  logic [3:0] dut_y_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [3:0] fail_mask_o,
    output logic [7:0] first_fail_vec_o,
    output logic       first_fail_valid_o
);

    // Anything shorter than 3 would sample before the synchronizer has caught up.
    localparam int S  = (SETTLE_CYCLES < 3) ? 3 : SETTLE_CYCLES;
    localparam int CW = $clog2(S);
    localparam logic [CW-1:0] CNT_INIT = CW'(S - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    vec_q, vec_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    drive_a_q, drive_a_d;
    logic [3:0]    drive_b_q, drive_b_d;
    logic [3:0]    fail_mask_q, fail_mask_d;
    logic [7:0]    ffv_q, ffv_d;
    logic          ffvalid_q, ffvalid_d;
    logic          pass_q, pass_d;
    logic [3:0]    y_meta_q, y_s_q;
    logic [3:0]    exp_y;
    logic [3:0]    mis;
    logic [7:0]    vec_nxt;

    // Two-flop synchronizer for the asynchronous gate outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            y_meta_q <= 4'h0;
            y_s_q    <= 4'h0;
        end else begin
            y_meta_q <= dut_y_i;
            y_s_q    <= y_meta_q;
        end
    end

    // Expected gate response and per-gate mismatch for the applied vector.
    always_comb begin
        exp_y = drive_a_q & drive_b_q;
        case (FUNC)
            1:       exp_y = ~(drive_a_q & drive_b_q);
            2:       exp_y = drive_a_q | drive_b_q;
            3:       exp_y = drive_a_q ^ drive_b_q;
            default: exp_y = drive_a_q & drive_b_q;
        endcase
        mis     = y_s_q ^ exp_y;
        vec_nxt = vec_q + 8'd1;
    end

    // Next-state and datapath updates; abort overrides everything outside IDLE.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        drive_a_d   = drive_a_q;
        drive_b_d   = drive_b_q;
        fail_mask_d = fail_mask_q;
        ffv_d       = ffv_q;
        ffvalid_d   = ffvalid_q;
        pass_d      = pass_q;
        done_o      = 1'b0;

        if (state_q != IDLE && abort_i) begin
            state_d   = IDLE;
            drive_a_d = 4'h0;
            drive_b_d = 4'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d     = SETTLE;
                        vec_d       = 8'h00;
                        drive_a_d   = 4'h0;
                        drive_b_d   = 4'h0;
                        cnt_d       = CNT_INIT;
                        fail_mask_d = 4'h0;
                        ffv_d       = 8'h00;
                        ffvalid_d   = 1'b0;
                        pass_d      = 1'b0;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = CHECK;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                CHECK: begin
                    fail_mask_d = fail_mask_q | mis;
                    if (mis != 4'h0 && !ffvalid_q) begin
                        ffv_d     = vec_q;
                        ffvalid_d = 1'b1;
                    end
                    if (vec_q == 8'hFF) begin
                        state_d = DONE;
                    end else begin
                        vec_d     = vec_nxt;
                        drive_a_d = vec_nxt[7:4];
                        drive_b_d = vec_nxt[3:0];
                        cnt_d     = CNT_INIT;
                        state_d   = SETTLE;
                    end
                end
                DONE: begin
                    done_o  = 1'b1;
                    pass_d  = (fail_mask_q == 4'h0);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            vec_q       <= 8'h00;
            cnt_q       <= '0;
            drive_a_q   <= 4'h0;
            drive_b_q   <= 4'h0;
            fail_mask_q <= 4'h0;
            ffv_q       <= 8'h00;
            ffvalid_q   <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            drive_a_q   <= drive_a_d;
            drive_b_q   <= drive_b_d;
            fail_mask_q <= fail_mask_d;
            ffv_q       <= ffv_d;
            ffvalid_q   <= ffvalid_d;
            pass_q      <= pass_d;
        end
    end

    assign busy_o             = (state_q != IDLE);
    assign drive_a_o          = drive_a_q;
    assign drive_b_o          = drive_b_q;
    assign pass_o             = pass_q;
    assign fail_mask_o        = fail_mask_q;
    assign first_fail_vec_o   = ffv_q;
    assign first_fail_valid_o = ffvalid_q;

endmodule

// File: tb/tb_quad_gate_bist_ctrl.sv
// Bench for quad_gate_bist_ctrl: an AND-package model with injectable
// stuck-at faults feeds the controller; full runs are table driven and
// abort, re-start, reset and parameter corner cases are hand sequenced.
module tb_quad_gate_bist_ctrl;

    typedef struct {
        string      name;
        logic [3:0] st0;
        logic [3:0] st1;
        logic [3:0] mask;
        logic [7:0] ffv;
        logic       ffvalid;
        logic       pass;
    } row_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // dut0: AND, settle 3
    logic       start0 = 1'b0, abort0 = 1'b0;
    logic [3:0] st0_0 = 4'h0, st1_0 = 4'h0;
    logic [3:0] da0, db0, y0, mask0;
    logic       busy0, done0, pass0, ffvalid0;
    logic [7:0] ffv0;

    // dut1: NAND expected, settle 1 (clamped to 3), wired to an ideal AND
    logic       start1 = 1'b0, abort1 = 1'b0;
    logic [3:0] da1, db1, y1, mask1;
    logic       busy1, done1, pass1, ffvalid1;
    logic [7:0] ffv1;

    int total = 0;
    int bad   = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    row_t rows[$];
    row_t sb[$];

    always #5 clk = ~clk;

    assign y0 = ((da0 & db0) & ~st0_0) | st1_0;
    assign y1 = da1 & db1;

    always @(posedge clk) begin
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
    end

    quad_gate_bist_ctrl #(.FUNC(0), .SETTLE_CYCLES(3)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start0), .abort_i(abort0),
        .drive_a_o(da0), .drive_b_o(db0), .dut_y_i(y0),
        .busy_o(busy0), .done_o(done0), .pass_o(pass0),
        .fail_mask_o(mask0), .first_fail_vec_o(ffv0),
        .first_fail_valid_o(ffvalid0)
    );

    quad_gate_bist_ctrl #(.FUNC(1), .SETTLE_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .abort_i(abort1),
        .drive_a_o(da1), .drive_b_o(db1), .dut_y_i(y1),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1),
        .fail_mask_o(mask1), .first_fail_vec_o(ffv1),
        .first_fail_valid_o(ffvalid1)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle0(input string tag);
        chk({tag, " busy"}, int'(busy0), 0);
        chk({tag, " done"}, int'(done0), 0);
        chk({tag, " pass"}, int'(pass0), 0);
        chk({tag, " mask"}, int'(mask0), 0);
        chk({tag, " ffv"}, int'(ffv0), 0);
        chk({tag, " ffvalid"}, int'(ffvalid0), 0);
        chk({tag, " drive_a"}, int'(da0), 0);
        chk({tag, " drive_b"}, int'(db0), 0);
    endtask

    // Pulse start on dut0; returns with n = negedges seen since the start edge.
    task automatic start_dut0(output int n);
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        n = 1;
        chk("busy after start", int'(busy0), 1);
    endtask

    task automatic run_row(input row_t r);
        int n;
        row_t e;
        st0_0 = r.st0;
        st1_0 = r.st1;
        sb.push_back(r);
        start_dut0(n);
        while (!done0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        if (!done0) begin
            chk({e.name, " done timeout"}, 0, 1);
        end else begin
            chk({e.name, " latency"}, n - 1, 1024);
            chk({e.name, " busy in done"}, int'(busy0), 1);
            @(negedge clk);
            chk({e.name, " done width"}, int'(done0), 0);
            chk({e.name, " busy after"}, int'(busy0), 0);
            chk({e.name, " pass"}, int'(pass0), int'(e.pass));
            chk({e.name, " mask"}, int'(mask0), int'(e.mask));
            chk({e.name, " ffv"}, int'(ffv0), int'(e.ffv));
            chk({e.name, " ffvalid"}, int'(ffvalid0), int'(e.ffvalid));
            chk({e.name, " drive_a hold"}, int'(da0), 15);
            chk({e.name, " drive_b hold"}, int'(db0), 15);
        end
    endtask

    initial begin
        int n;
        int dc;

        rows.push_back('{"ideal",      4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1});
        rows.push_back('{"g3_sa0",     4'h4, 4'h0, 4'h4, 8'h44, 1'b1, 1'b0});
        rows.push_back('{"g4_sa1",     4'h0, 4'h8, 4'h8, 8'h00, 1'b1, 1'b0});
        rows.push_back('{"g2_sa0",     4'h2, 4'h0, 4'h2, 8'h22, 1'b1, 1'b0});
        rows.push_back('{"g1_sa1",     4'h0, 4'h1, 4'h1, 8'h00, 1'b1, 1'b0});
        rows.push_back('{"ideal_again",4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1});

        #1;
        chk_idle0("reset");
        chk("reset dut1 busy", int'(busy1), 0);
        chk("reset dut1 mask", int'(mask1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (rows[i]) run_row(rows[i]);

        // NAND expectation against AND hardware, with a redundant start at cycle 300.
        dc = done_cnt1;
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        n = 1;
        while (!done1 && n < 2000) begin
            @(negedge clk);
            n++;
            if (n == 300) start1 = 1'b1;
            if (n == 301) start1 = 1'b0;
        end
        if (!done1) begin
            chk("nand done timeout", 0, 1);
        end else begin
            chk("nand latency", n - 1, 1024);
            @(negedge clk);
            chk("nand done count", done_cnt1 - dc, 1);
            chk("nand mask", int'(mask1), 15);
            chk("nand ffv", int'(ffv1), 0);
            chk("nand ffvalid", int'(ffvalid1), 1);
            chk("nand pass", int'(pass1), 0);
        end
        repeat (1100) @(negedge clk);
        chk("nand restart ignored", done_cnt1 - dc, 1);
        chk("nand busy idle", int'(busy1), 0);

        // Abort at cycle 500 with gate 3 stuck low: partial results survive.
        st0_0 = 4'h4;
        st1_0 = 4'h0;
        dc = done_cnt0;
        start_dut0(n);
        while (n < 500) begin
            @(negedge clk);
            n++;
        end
        abort0 = 1'b1;
        @(posedge clk);
        #1;
        chk("abort busy", int'(busy0), 0);
        chk("abort drive_a", int'(da0), 0);
        chk("abort drive_b", int'(db0), 0);
        @(negedge clk);
        abort0 = 1'b0;
        repeat (1100) @(negedge clk);
        chk("abort no done", done_cnt0 - dc, 0);
        chk("abort pass", int'(pass0), 0);
        chk("abort mask kept", int'(mask0), 4);
        chk("abort ffv kept", int'(ffv0), 8'h44);
        chk("abort ffvalid kept", int'(ffvalid0), 1);

        run_row('{"after_abort", 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1});

        // Asynchronous reset mid-run clears every output before the next edge.
        st1_0 = 4'h8;
        dc = done_cnt0;
        start_dut0(n);
        repeat (200) @(negedge clk);
        chk("pre-reset mask", int'(mask0), 8);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle0("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        st1_0 = 4'h0;
        repeat (1100) @(negedge clk);
        chk("reset no done", done_cnt0 - dc, 0);
        chk("reset stays idle", int'(busy0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/quad_gate_bist_ctrl.md
# quad_gate_bist_ctrl

Built-in self-test controller for one quad 2-input gate package (74LS08 AND, and its NAND/OR/XOR siblings). It drives all four gates together through all 256 input combinations. It samples the four outputs after a programmable settle time, checks them against the expected gate function, and reports a per-gate fail mask plus the first failing vector. It sits between the bench or board sequencer and the gate package pins.

## Interface
Parameters:
- FUNC, 0: expected gate function; 0 AND, 1 NAND, 2 OR, 3 XOR.
- SETTLE_CYCLES, 3: cycles between a drive change and the sample. Values below 3 are treated as 3, which covers the 2-flop synchronizer.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  synchronous stop; takes effect in any non-IDLE state.
- drive_a  out  4  gate A inputs; bit i drives gate i+1.
- drive_b  out  4  gate B inputs; bit i drives gate i+1.
- dut_y  in  4  gate outputs; bit i comes from gate i+1; asynchronous to clk.
- busy  out  1  high while a run is in progress, including the DONE cycle.
- done  out  1  one-cycle pulse when a run completes.
- pass  out  1  high when the last completed run had no mismatch; held until the next start.
- fail_mask  out  4  sticky per-gate mismatch flags.
- first_fail_vec  out  8  vector index of the first mismatch.
- first_fail_valid  out  1  first_fail_vec holds a captured vector.

## Operation
- dut_y passes continuously through a 2-flop synchronizer, giving y_s.
- Vector index vec is 8 bits: drive_a = vec[7:4], drive_b = vec[3:0]. drive_a/drive_b are registered.
- Let S = max(SETTLE_CYCLES, 3). Settle counter cnt needs ceil(log2 S) bits.
- FSM states: IDLE, SETTLE, CHECK, DONE.
  - IDLE with start=1: vec←0, drive←0, cnt←S−1, fail_mask←0, first_fail_valid←0, first_fail_vec←0, pass←0; go to SETTLE.
  - SETTLE: if cnt==0 go to CHECK, else cnt←cnt−1.
  - CHECK:
    - exp = FUNC(drive_a, drive_b), bitwise.
    - mis = y_s ^ exp.
    - fail_mask ← fail_mask | mis.
    - If mis≠0 and !first_fail_valid: first_fail_vec←vec, first_fail_valid←1.
    - If vec==255 go to DONE. Otherwise vec←vec+1, drive←next vec, cnt←S−1, go to SETTLE.
  - DONE: done=1; pass←(fail_mask==0), using the value after the last CHECK update; go to IDLE. drive_a/drive_b are left at 0xFF.
- abort in SETTLE, CHECK or DONE:
  - Go to IDLE; drive←0.
  - No done pulse; pass stays 0.
  - fail_mask and first_fail_* keep their partial results. Any CHECK update in that same cycle is suppressed.
- start while busy is ignored. start and abort together in IDLE: the run starts and abort is ignored.
- vec never wraps. The CHECK at 255 always exits to DONE.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and both synchronizer flops are 0. Reset mid-run aborts immediately with no done pulse.
- Edge E0 samples start. busy is high from the cycle after E0.
- Each vector takes S+1 cycles: S in SETTLE, then 1 in CHECK.
- DONE is entered at edge E0+256·(S+1), with done and busy high for that one cycle. At S=3, done is high from edge E0+1024 to edge E0+1025.
- The sample taken in CHECK reflects dut_y as it was at least S−2 cycles after the drive change.
- fail_mask and first_fail_* update on the edge leaving CHECK. pass updates on the edge leaving DONE, so it is valid from the cycle after done.
- abort sampled at edge Ea: busy is low and drive is 0 from Ea.

## Test plan
- Ideal AND model, FUNC=0, S=3: pulse start → done exactly 1024 cycles after the start edge; pass=1, fail_mask=0, first_fail_valid=0; drive holds 0xFF.
- Gate 3 output stuck-at-0 → fail_mask=4'b0100, first_fail_vec=0x44, first_fail_valid=1, pass=0.
- Gate 4 output stuck-at-1 → fail_mask=4'b1000, first_fail_vec=0x00, pass=0.
- FUNC=1 (NAND) against an ideal AND model → fail_mask=4'hF, first_fail_vec=0x00.
- SETTLE_CYCLES=1 → behaves as S=3, done at 1024 cycles. start pulsed again at cycle 300 → ignored.
- abort at cycle 500 → busy=0 and drive=0 next edge, done never pulses, pass=0. A following start clears fail_mask and runs a full pass. rst_n low mid-run → all outputs 0 asynchronously.
